// File: rtl/xnor_stream_checker.sv
// Bit-serial frame comparator: XNORs two serial streams over a fixed-length
// frame, counting mismatches and recording where the first one occurred.
module xnor_stream_checker #(
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             in_valid,
  input  logic             a,
  input  logic             b,
  output logic             busy,
  output logic             done,
  output logic             equal,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] first_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);

  // Mismatch counter sticks at all-ones rather than wrapping on long frames.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  logic [1:0]       state_q, state_d;
  logic [7:0]       idx_q, idx_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] ferr_q, ferr_d;
  logic             equal_q, equal_d;
  logic             match;

  assign match = ~(a ^ b);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = err_q;
    ferr_d  = ferr_q;
    equal_d = equal_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          idx_d   = '0;
          err_d   = '0;
          ferr_d  = '0;
          equal_d = 1'b0;
        end
      end
      S_RUN: begin
        // Abort wins over a same-edge bit, including the final one.
        if (abort) begin
          state_d = S_IDLE;
        end else if (in_valid) begin
          idx_d = idx_q + 8'd1;
          if (!match) begin
            err_d = sat_inc(err_q);
            if (err_q == '0) ferr_d = CNT_W'(idx_q);
          end
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
            equal_d = (err_d == '0);
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      err_q   <= '0;
      ferr_q  <= '0;
      equal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      ferr_q  <= ferr_d;
      equal_q <= equal_d;
    end
  end

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign equal     = equal_q;
  assign err_cnt   = err_q;
  assign first_err = ferr_q;

endmodule

// File: tb/tb_xnor_stream_checker.sv
// Directed bench for xnor_stream_checker: default 8-bit frame, plus
// FRAME_LEN=20 (saturation) and FRAME_LEN=1 instances.
module tb_xnor_stream_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start, abort, in_valid, a, b;
  logic       busy, done, equal;
  logic [3:0] err_cnt, first_err;

  logic       s20_start, s20_abort, s20_iv, s20_a, s20_b;
  logic       s20_busy, s20_done, s20_equal;
  logic [3:0] s20_err, s20_ferr;

  logic       s1_start, s1_abort, s1_iv, s1_a, s1_b;
  logic       s1_busy, s1_done, s1_equal;
  logic [3:0] s1_err, s1_ferr;

  int n_checks = 0;
  int n_err    = 0;
  int done_cnt = 0;
  int d0;

  xnor_stream_checker #(.FRAME_LEN(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .in_valid(in_valid),
    .a(a), .b(b), .busy(busy), .done(done), .equal(equal),
    .err_cnt(err_cnt), .first_err(first_err)
  );

  xnor_stream_checker #(.FRAME_LEN(20), .CNT_W(4)) dut20 (
    .clk(clk), .rst_n(rst_n), .start(s20_start), .abort(s20_abort), .in_valid(s20_iv),
    .a(s20_a), .b(s20_b), .busy(s20_busy), .done(s20_done), .equal(s20_equal),
    .err_cnt(s20_err), .first_err(s20_ferr)
  );

  xnor_stream_checker #(.FRAME_LEN(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(s1_start), .abort(s1_abort), .in_valid(s1_iv),
    .a(s1_a), .b(s1_b), .busy(s1_busy), .done(s1_done), .equal(s1_equal),
    .err_cnt(s1_err), .first_err(s1_ferr)
  );

  always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Start a frame and send 8 bits (bit 0 first); optional 0/1/5-cycle gaps
  // with a!=b, and optional start toggling while busy. Returns in the DONE cycle.
  task automatic run_frame(input logic [7:0] pa, input logic [7:0] pb,
                           input bit gapped, input bit toggle);
    int gap;
    start = 1'b1;
    tick;
    start = 1'b0;
    check("frame_busy_start", 32'(busy), 1);
    for (int i = 0; i < 8; i++) begin
      a = pa[i];
      b = pb[i];
      in_valid = 1'b1;
      tick;
      in_valid = 1'b0;
      if (i < 7) begin
        gap = gapped ? ((i % 3 == 0) ? 0 : (i % 3 == 1) ? 1 : 5) : 0;
        for (int g = 0; g < gap; g++) begin
          a = 1'b1;
          b = 1'b0;
          start = toggle;
          tick;
        end
        start = 1'b0;
        check("frame_busy_mid", 32'(busy), 1);
      end
    end
    check("frame_done", 32'(done), 1);
    check("frame_busy_end", 32'(busy), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    {start, abort, in_valid, a, b} = '0;
    {s20_start, s20_abort, s20_iv, s20_a, s20_b} = '0;
    {s1_start, s1_abort, s1_iv, s1_a, s1_b} = '0;
    tick;
    tick;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_equal", 32'(equal), 0);
    check("rst_err", 32'(err_cnt), 0);
    check("rst_ferr", 32'(first_err), 0);
    rst_n = 1'b1;
    tick;

    // All-match frame, then start during DONE is ignored
    d0 = done_cnt;
    run_frame(8'b10110010, 8'b10110010, 1'b0, 1'b0);
    check("match_equal", 32'(equal), 1);
    check("match_err", 32'(err_cnt), 0);
    start = 1'b1;
    tick;
    check("start_in_done_busy", 32'(busy), 0);
    check("match_done_gone", 32'(done), 0);
    check("match_equal_hold", 32'(equal), 1);
    check("match_done_pulses", done_cnt - d0, 1);
    tick;
    check("start_after_done_busy", 32'(busy), 1);
    check("start_clears_equal", 32'(equal), 0);
    start = 1'b0;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    check("abort_idle_busy", 32'(busy), 0);

    // Mismatch frame: xor = 00100001 -> bits 0 and 5
    d0 = done_cnt;
    run_frame(8'b10110010, 8'b10010011, 1'b0, 1'b0);
    check("mis_err", 32'(err_cnt), 2);
    check("mis_ferr", 32'(first_err), 0);
    check("mis_equal", 32'(equal), 0);
    tick;
    check("mis_done_pulses", done_cnt - d0, 1);
    check("mis_err_hold", 32'(err_cnt), 2);

    // Same mismatch frame with gaps and start toggling while busy
    d0 = done_cnt;
    run_frame(8'b10110010, 8'b10010011, 1'b1, 1'b1);
    check("gap_err", 32'(err_cnt), 2);
    check("gap_ferr", 32'(first_err), 0);
    check("gap_equal", 32'(equal), 0);
    tick;
    check("gap_done_pulses", done_cnt - d0, 1);

    // xor = 10001000 -> bits 3 and 7 (last bit mismatches)
    run_frame(8'b11111111, 8'b01110111, 1'b1, 1'b0);
    check("late_err", 32'(err_cnt), 2);
    check("late_ferr", 32'(first_err), 3);
    check("late_equal", 32'(equal), 0);
    tick;

    // Abort on bit 5
    d0 = done_cnt;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a = (i == 0);
      b = 1'b0;
      in_valid = 1'b1;
      tick;
      in_valid = 1'b0;
      if (i == 0) check("err_after_bit0", 32'(err_cnt), 1);
    end
    a = 1'b1;
    b = 1'b0;
    in_valid = 1'b1;
    abort = 1'b1;
    tick;
    in_valid = 1'b0;
    abort = 1'b0;
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_equal", 32'(equal), 0);
    check("abort_err_partial", 32'(err_cnt), 1);
    tick;
    tick;
    tick;
    check("abort_no_done", done_cnt - d0, 0);
    run_frame(8'b01010101, 8'b01010101, 1'b0, 1'b0);
    check("post_abort_equal", 32'(equal), 1);
    check("post_abort_err", 32'(err_cnt), 0);
    tick;

    // Abort on the same edge as the final bit
    d0 = done_cnt;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      a = 1'b0;
      b = 1'b0;
      in_valid = 1'b1;
      tick;
    end
    abort = 1'b1;
    tick;
    abort = 1'b0;
    in_valid = 1'b0;
    check("abort_last_busy", 32'(busy), 0);
    check("abort_last_done", 32'(done), 0);
    tick;
    check("abort_last_no_done", done_cnt - d0, 0);

    // Reset asserted mid-frame
    d0 = done_cnt;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a = 1'b1;
      b = 1'b0;
      in_valid = 1'b1;
      tick;
    end
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_done", 32'(done), 0);
    check("midrst_equal", 32'(equal), 0);
    check("midrst_err", 32'(err_cnt), 0);
    check("midrst_ferr", 32'(first_err), 0);
    tick;
    rst_n = 1'b1;
    tick;
    check("midrst_no_done", done_cnt - d0, 0);
    run_frame(8'b11111111, 8'b01110111, 1'b0, 1'b0);
    check("after_rst_err", 32'(err_cnt), 2);
    check("after_rst_ferr", 32'(first_err), 3);
    tick;

    // FRAME_LEN=20: mismatch counter saturates
    s20_start = 1'b1;
    tick;
    s20_start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      s20_a = 1'b1;
      s20_b = 1'b0;
      s20_iv = 1'b1;
      tick;
      if (i == 14) check("sat_err_at15", 32'(s20_err), 15);
      if (i == 18) check("sat_busy_at19", 32'(s20_busy), 1);
    end
    s20_iv = 1'b0;
    check("sat_done", 32'(s20_done), 1);
    check("sat_err", 32'(s20_err), 15);
    check("sat_ferr", 32'(s20_ferr), 0);
    check("sat_equal", 32'(s20_equal), 0);
    tick;
    check("sat_done_gone", 32'(s20_done), 0);

    // FRAME_LEN=1: single bit goes straight to DONE
    s1_start = 1'b1;
    tick;
    s1_start = 1'b0;
    check("len1_busy", 32'(s1_busy), 1);
    s1_a = 1'b0;
    s1_b = 1'b1;
    s1_iv = 1'b1;
    tick;
    s1_iv = 1'b0;
    check("len1_done", 32'(s1_done), 1);
    check("len1_busy_end", 32'(s1_busy), 0);
    check("len1_err", 32'(s1_err), 1);
    check("len1_ferr", 32'(s1_ferr), 0);
    check("len1_equal", 32'(s1_equal), 0);
    tick;
    s1_start = 1'b1;
    tick;
    s1_start = 1'b0;
    s1_a = 1'b1;
    s1_b = 1'b1;
    s1_iv = 1'b1;
    tick;
    s1_iv = 1'b0;
    check("len1_match_done", 32'(s1_done), 1);
    check("len1_match_equal", 32'(s1_equal), 1);
    check("len1_match_err", 32'(s1_err), 0);
    tick;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
